// File: rtl/iob_axi_mem_arb_if.sv
// AXI4 single-beat master/slave bundle between the arbiter and the DDR port.
interface iob_axi_mem_arb_if #(
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic                  awvalid, awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid, wready, wlast;
    logic [DATA_W-1:0]     wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic                  arvalid, arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid, rready, rlast;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/iob_axi_mem_arb.sv
// Round-robin arbiter: two iob native masters share one AXI4 port, one
// single-beat transaction in flight at a time.
module iob_axi_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*DATA_W/8-1:0] req_wstrb,
    output logic [DATA_W-1:0]     req_rdata,
    output logic [1:0]            req_ready,
    output logic                  err,
    iob_axi_mem_arb_if.master     m_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT_B, WAIT_R, DONE} state_t;

    state_t              state, state_nxt;
    logic                grant, last_grant, sel;
    logic                aw_done, w_done;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg, rdata_reg;
    logic [STRB_W-1:0]   wstrb_reg, sel_wstrb;
    logic [AXI_ADDR_W-1:0] axi_addr;

    // On contention favour whoever did not win last time.
    assign sel       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign sel_wstrb = sel ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];

    generate
        if (ADDR_W >= AXI_ADDR_W) begin : g_addr_trunc
            assign axi_addr = addr_reg[AXI_ADDR_W-1:0];
        end else begin : g_addr_zext
            assign axi_addr = {{(AXI_ADDR_W-ADDR_W){1'b0}}, addr_reg};
        end
    endgenerate

    assign req_rdata = rdata_reg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and AXI/requester strobes; outputs derive from state so reset drops them at once.
    always_comb begin
        state_nxt      = state;
        m_axi.awvalid  = 1'b0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        req_ready      = 2'b00;
        case (state)
            IDLE:   if (|req_valid) state_nxt = (|sel_wstrb) ? WR : RD;
            WR: begin
                m_axi.awvalid = ~aw_done;
                m_axi.wvalid  = ~w_done;
                if ((aw_done || m_axi.awready) && (w_done || m_axi.wready))
                    state_nxt = WAIT_B;
            end
            RD: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) state_nxt = WAIT_R;
            end
            WAIT_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_nxt = DONE;
            end
            WAIT_R: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) state_nxt = DONE;
            end
            DONE: begin
                req_ready = grant ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/request latch, per-channel handshake tracking, response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            rdata_reg  <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    grant      <= sel;
                    last_grant <= sel;
                    addr_reg   <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    wdata_reg  <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    wstrb_reg  <= sel_wstrb;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                end
                WR: begin
                    if (m_axi.awvalid && m_axi.awready) aw_done <= 1'b1;
                    if (m_axi.wvalid && m_axi.wready)   w_done  <= 1'b1;
                end
                WAIT_B: if (m_axi.bvalid) begin
                    rdata_reg <= '0;
                    if (m_axi.bresp != 2'b00) err <= 1'b1;
                end
                WAIT_R: if (m_axi.rvalid) begin
                    rdata_reg <= m_axi.rdata;
                    if (m_axi.rresp != 2'b00) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Constant single-beat INCR attributes; ID carries the requester index.
    assign m_axi.awaddr  = axi_addr;
    assign m_axi.araddr  = axi_addr;
    assign m_axi.awid    = AXI_ID_W'(grant);
    assign m_axi.arid    = AXI_ID_W'(grant);
    assign m_axi.awlen   = 8'd0;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.arburst = 2'b01;
    assign m_axi.wdata   = wdata_reg;
    assign m_axi.wstrb   = wstrb_reg;
    assign m_axi.wlast   = 1'b1;
endmodule

// File: tb/tb_iob_axi_mem_arb.sv
// Bench for iob_axi_mem_arb: small AXI slave model, per-requester
// expected-response queues popped by a monitor on each req_ready pulse.
module tb_iob_axi_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [31:0] req_rdata;
    logic [1:0]  req_ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          grant_log[$];

    iob_axi_mem_arb_if #(.DATA_W(32), .AXI_ADDR_W(32), .AXI_ID_W(4)) m_axi ();

    iob_axi_mem_arb #(.ADDR_W(32), .DATA_W(32), .AXI_ADDR_W(32), .AXI_ID_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
        .req_ready(req_ready), .err(err), .m_axi(m_axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- AXI slave model ----------------
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  rresp_inj = 2'b00;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        got_aw, got_w, r_pend;
    logic [31:0] wa_addr, w_data;
    logic [3:0]  w_strb;
    logic [31:0] mem [0:255];

    function automatic logic [31:0] preload(int k);
        if (k == 64)      return 32'hDEADBEEF;
        else if (k == 16) return 32'hAABBCCDD;
        else              return 32'hC0DE0000 | 32'(k);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign m_axi.awready = m_axi.awvalid && !got_aw && (aw_cnt >= aw_wait);
    assign m_axi.wready  = m_axi.wvalid && !got_w && (w_cnt >= w_wait);
    assign m_axi.arready = m_axi.arvalid && !m_axi.rvalid && !r_pend && (ar_cnt >= ar_wait);
    assign m_axi.bresp   = 2'b00;
    assign m_axi.rlast   = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            wa_addr <= '0; w_data <= '0; w_strb <= '0;
            m_axi.bvalid <= 1'b0; m_axi.rvalid <= 1'b0;
            m_axi.rdata <= '0; m_axi.rresp <= 2'b00;
            for (int k = 0; k < 256; k++) mem[k] <= preload(k);
        end else begin
            if (m_axi.awvalid && !m_axi.awready) aw_cnt <= aw_cnt + 1;
            if (m_axi.awvalid && m_axi.awready) begin
                got_aw <= 1'b1; wa_addr <= m_axi.awaddr; aw_cnt <= 0;
            end
            if (m_axi.wvalid && !m_axi.wready) w_cnt <= w_cnt + 1;
            if (m_axi.wvalid && m_axi.wready) begin
                got_w <= 1'b1; w_data <= m_axi.wdata; w_strb <= m_axi.wstrb; w_cnt <= 0;
            end
            if ((got_aw || (m_axi.awvalid && m_axi.awready)) &&
                (got_w || (m_axi.wvalid && m_axi.wready)) && !m_axi.bvalid) begin
                mem[got_aw ? wa_addr[9:2] : m_axi.awaddr[9:2]] <=
                    merge(mem[got_aw ? wa_addr[9:2] : m_axi.awaddr[9:2]],
                          got_w ? w_data : m_axi.wdata, got_w ? w_strb : m_axi.wstrb);
                m_axi.bvalid <= 1'b1;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;

            if (m_axi.arvalid && !m_axi.arready) ar_cnt <= ar_cnt + 1;
            if (m_axi.arvalid && m_axi.arready) begin
                ar_cnt <= 0;
                m_axi.rdata <= mem[m_axi.araddr[9:2]];
                m_axi.rresp <= rresp_inj;
                if (r_wait == 0) m_axi.rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= 1; end
            end
            if (r_pend) begin
                if (r_cnt >= r_wait) begin m_axi.rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt + 1;
            end
            if (m_axi.rvalid && m_axi.rready) m_axi.rvalid <= 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst && req_ready != 2'b00) begin
            chk("ready_onehot", 64'(req_ready == 2'b11), 64'd0);
            if (req_ready[0]) begin
                grant_log.push_back(0);
                if (exp_q0.size() == 0) chk("unexpected_ready0", 64'd1, 64'd0);
                else chk("rdata_req0", 64'(req_rdata), 64'(exp_q0.pop_front()));
            end
            if (req_ready[1]) begin
                grant_log.push_back(1);
                if (exp_q1.size() == 0) chk("unexpected_ready1", 64'd1, 64'd0);
                else chk("rdata_req1", 64'(req_rdata), 64'(exp_q1.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4]   = s;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_ready(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[i]) seen = 1'b1;
        end
        if (!seen) chk("ready_timeout", 64'(i), 64'hFF);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp);
        if (i == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        drive(i, a, d, s);
        wait_ready(i);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_req_rdata", 64'(req_rdata), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_valids", 64'({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}), 64'd0);

        // Zero-wait read by requester 0: arvalid cycle 1, req_ready cycle 3.
        @(posedge clk); #1;
        exp_q0.push_back(32'hDEADBEEF);
        drive(0, 32'h100, 32'h0, 4'h0);
        @(negedge clk); chk("t1_c0_arvalid", 64'(m_axi.arvalid), 64'd0);
        @(negedge clk);
        chk("t1_c1_arvalid", 64'(m_axi.arvalid), 64'd1);
        chk("t1_arid", 64'(m_axi.arid), 64'd0);
        chk("t1_araddr", 64'(m_axi.araddr), 64'h100);
        chk("t1_arlen_size_burst", 64'({m_axi.arlen, m_axi.arsize, m_axi.arburst}), 64'({8'd0, 3'd2, 2'b01}));
        @(negedge clk);
        chk("t1_c2_rready", 64'(m_axi.rready), 64'd1);
        chk("t1_c2_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("t1_c3_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_ready_pulse", 64'(req_ready), 64'd0);
        chk("t1_rdata_hold", 64'(req_rdata), 64'hDEADBEEF);

        // Write by requester 1 with wready lagging awready by 3 cycles.
        w_wait = 3;
        @(posedge clk); #1;
        exp_q1.push_back(32'h0);
        drive(1, 32'h40, 32'h12345678, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        chk("t2_c1_aw_w_valid", 64'({m_axi.awvalid, m_axi.wvalid}), 64'b11);
        chk("t2_awid", 64'(m_axi.awid), 64'd1);
        chk("t2_awaddr", 64'(m_axi.awaddr), 64'h40);
        chk("t2_wdata", 64'(m_axi.wdata), 64'h12345678);
        chk("t2_wstrb_wlast", 64'({m_axi.wstrb, m_axi.wlast}), 64'({4'b0011, 1'b1}));
        @(negedge clk);
        chk("t2_c2_aw_w_valid", 64'({m_axi.awvalid, m_axi.wvalid}), 64'b01);
        wait_ready(1);
        w_wait = 0;
        @(posedge clk); #1;
        req(0, 32'h40, 32'h0, 4'h0, 32'hAABB5678);
        @(posedge clk); #1;
        chk("t2_err", 64'(err), 64'd0);

        // Contention: both requesters read 8 times; grants must alternate from 0.
        do_reset();
        @(posedge clk); #1;
        grant_log.delete();
        fork
            for (int k = 0; k < 8; k++) begin
                req(0, 32'h200 + 32'(4*k), 32'h0, 4'h0, 32'hC0DE0080 + 32'(k));
                @(posedge clk); #1;
            end
            for (int k = 0; k < 8; k++) begin
                req(1, 32'h300 + 32'(4*k), 32'h0, 4'h0, 32'hC0DE00C0 + 32'(k));
                @(posedge clk); #1;
            end
        join
        chk("t3_grant_count", 64'(grant_log.size()), 64'd16);
        for (int k = 0; k < grant_log.size() && k < 16; k++)
            chk($sformatf("t3_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));

        // SLVERR on a read sets sticky err; transaction still completes.
        rresp_inj = 2'b10;
        req(0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
        rresp_inj = 2'b00;
        @(negedge clk);
        chk("t4_err_set", 64'(err), 64'd1);
        @(posedge clk); #1;
        req(1, 32'h104, 32'h0, 4'h0, 32'hC0DE0041);
        @(negedge clk);
        chk("t4_err_sticky", 64'(err), 64'd1);

        // Reset while waiting for R: everything drops asynchronously.
        r_wait = 20;
        @(posedge clk); #1;
        drive(0, 32'h108, 32'h0, 4'h0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                if (m_axi.rready) seen = 1'b1;
            end
            chk("t5_reach_wait_r", 64'(seen), 64'd1);
        end
        #2 rst = 1'b0;
        req_valid = '0;
        #1;
        chk("t5_async_valids", 64'({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}), 64'd0);
        chk("t5_async_ready_err", 64'({req_ready, err}), 64'd0);
        chk("t5_async_rdata", 64'(req_rdata), 64'd0);
        r_wait = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        req(0, 32'h10C, 32'h0, 4'h0, 32'hC0DE0043);
        @(negedge clk);
        chk("t5_queues_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
